// File: rtl/riscv_store_unit_pkg.sv
// Shared types and lane constants for the store unit and its merge helper.
package riscv_store_unit_pkg;

  typedef enum logic [2:0] {
    MASK_X      = 3'd0,
    MASK_B      = 3'd1,
    MASK_H      = 3'd2,
    MASK_B_SEXT = 3'd3,
    MASK_H_SEXT = 3'd4
  } MASK_SEL;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    RDWAIT = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } STORE_STATE;

  localparam logic [31:0] RG_SB_MASK      = 32'h0000_00FF;
  localparam logic [31:0] RG_SH_MASK      = 32'h0000_FFFF;
  localparam logic [31:0] RG_SB_LANE_MASK = 32'h0000_00FF;
  localparam logic [31:0] RG_SH_LANE_MASK = 32'h0000_FFFF;

endpackage

// File: rtl/riscv_store_unit_merge.sv
// Splices a byte or halfword of store data into the correct lane of a word read from RAM.
module riscv_store_merge
  import riscv_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] data,
  input  logic [2:0]  sel,
  input  logic [1:0]  offset,
  output logic [31:0] merged
);

  logic [4:0] sh_b;
  logic [4:0] sh_h;

  assign sh_b = {offset, 3'b000};
  assign sh_h = {offset[1], 4'b0000};

  always_comb begin
    merged = rdata;
    case (MASK_SEL'(sel))
      MASK_X:  merged = data;
      MASK_B:  merged = (rdata & ~(RG_SB_LANE_MASK << sh_b)) | ((data & RG_SB_MASK) << sh_b);
      MASK_H:  merged = (rdata & ~(RG_SH_LANE_MASK << sh_h)) | ((data & RG_SH_MASK) << sh_h);
      default: merged = rdata;
    endcase
  end

endmodule

// File: rtl/riscv_store_unit.sv
// Store unit for a RAM without byte enables: word stores write directly,
// sub-word stores read-modify-write, misaligned/illegal requests finish with an error.
module riscv_store_unit
  import riscv_store_unit_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_LENGTH-1:0] req_addr,
  input  logic [WORD_LENGTH-1:0] req_data,
  input  logic [2:0]             req_mask_sel,
  output logic [ADDR_LENGTH-1:0] mem_addr,
  output logic                   mem_re,
  input  logic [WORD_LENGTH-1:0] mem_rdata,
  output logic                   mem_we,
  output logic [WORD_LENGTH-1:0] mem_wdata,
  output logic                   done_valid,
  output logic                   done_err
);

  STORE_STATE             state;
  logic [ADDR_LENGTH-1:0] addr_q;
  logic [WORD_LENGTH-1:0] data_q;
  logic [2:0]             sel_q;
  logic                   err_q;
  logic [WORD_LENGTH-1:0] merged;

  function automatic logic illegal_req(input logic [2:0] sel, input logic [1:0] off);
    case (MASK_SEL'(sel))
      MASK_X:  return off != 2'b00;
      MASK_B:  return 1'b0;
      MASK_H:  return off[0];
      default: return 1'b1;
    endcase
  endfunction

  riscv_store_merge u_merge (
    .rdata  (mem_rdata),
    .data   (data_q),
    .sel    (sel_q),
    .offset (addr_q[1:0]),
    .merged (merged)
  );

  // All outputs are registers, so nothing on req_* reaches mem_* combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      sel_q      <= '0;
      err_q      <= 1'b0;
      req_ready  <= 1'b1;
      mem_addr   <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      done_valid <= 1'b0;
      done_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            data_q    <= req_data;
            sel_q     <= req_mask_sel;
            req_ready <= 1'b0;
            if (illegal_req(req_mask_sel, req_addr[1:0])) begin
              err_q      <= 1'b1;
              done_valid <= 1'b1;
              done_err   <= 1'b1;
              state      <= DONE;
            end else if (req_mask_sel == MASK_X) begin
              err_q     <= 1'b0;
              mem_addr  <= {req_addr[ADDR_LENGTH-1:2], 2'b00};
              mem_wdata <= req_data;
              mem_we    <= 1'b1;
              state     <= WRITE;
            end else begin
              err_q    <= 1'b0;
              mem_addr <= {req_addr[ADDR_LENGTH-1:2], 2'b00};
              mem_re   <= 1'b1;
              state    <= READ;
            end
          end
        end
        READ: begin
          mem_re <= 1'b0;
          state  <= RDWAIT;
        end
        // RAM data for the READ strobe is valid in this cycle.
        RDWAIT: begin
          mem_addr  <= {addr_q[ADDR_LENGTH-1:2], 2'b00};
          mem_wdata <= merged;
          mem_we    <= 1'b1;
          state     <= WRITE;
        end
        WRITE: begin
          mem_we     <= 1'b0;
          done_valid <= 1'b1;
          done_err   <= err_q;
          state      <= DONE;
        end
        DONE: begin
          done_valid <= 1'b0;
          done_err   <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          mem_re     <= 1'b0;
          mem_we     <= 1'b0;
          done_valid <= 1'b0;
          done_err   <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/riscv_store_unit.md
# riscv_store_unit

Store-side counterpart of the load-data mask: it accepts SB/SH/SW requests from the execute stage and writes them into a word-wide data RAM that has no byte enables. Sub-word stores use read-modify-write: read the containing word, splice the byte or halfword into the correct lane, write it back. Word stores write directly. Misaligned or illegal requests complete with an error and never touch memory.

## Interface
- WORD_LENGTH, 32, data width; only 32 is supported.
- ADDR_LENGTH, 32, byte address width.

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit idle; request accepted when req_valid && req_ready.
- req_addr  in  ADDR_LENGTH  byte address.
- req_data  in  WORD_LENGTH  rs2 value; store data sits in the low bits.
- req_mask_sel  in  MASK_SEL  MASK_X = word, MASK_B = byte, MASK_H = halfword. MASK_B_SEXT, MASK_H_SEXT and any other value are illegal.
- mem_addr  out  ADDR_LENGTH  word address {addr[ADDR_LENGTH-1:2], 2'b00}.
- mem_re  out  1  RAM read strobe; mem_rdata is valid exactly one cycle later.
- mem_rdata  in  WORD_LENGTH  RAM read data.
- mem_we  out  1  RAM write strobe.
- mem_wdata  out  WORD_LENGTH  full word to write.
- done_valid  out  1  one-cycle completion pulse.
- done_err  out  1  qualified by done_valid; 1 = misaligned or illegal, no write performed.

## Operation
- FSM states: IDLE, READ, RDWAIT, WRITE, DONE.
- **IDLE**
  - req_ready = 1.
  - On accept, latch addr, data and sel into registers, then branch:
    - Illegal sel, MASK_H with addr[0] = 1, or MASK_X with addr[1:0] != 0: set err and go to DONE.
    - MASK_X aligned: merged = req_data; go to WRITE.
    - MASK_B, or aligned MASK_H: go to READ.
- **READ**: mem_re = 1, mem_addr = word address; go to RDWAIT.
- **RDWAIT**
  - Sample mem_rdata and register merged; go to WRITE.
  - Byte store, lane k = addr[1:0]: merged = (rdata & ~(8'hFF << 8k)) | ((data & RG_SB_MASK) << 8k).
  - Halfword store, lane h = addr[1]: merged = (rdata & ~(16'hFFFF << 16h)) | ((data & RG_SH_MASK) << 16h).
- **WRITE**: mem_we = 1, mem_addr = word address, mem_wdata = merged; go to DONE.
- **DONE**: done_valid = 1, done_err = err; go to IDLE.
- Request fields are ignored outside IDLE. The upstream stage holds them, but the unit uses only the latched copies.
- mem_re and mem_we are never asserted together.
- Outside READ/WRITE, mem_addr and mem_wdata hold their last values; they have no meaning there.
- Bits of req_data above the store width are discarded.

## Timing
- Reset (asynchronous assert, synchronous release): state = IDLE, all latches = 0.
  - req_ready = 1.
  - mem_re = mem_we = 0; mem_addr = 0; mem_wdata = 0.
  - done_valid = done_err = 0.
- Latency, accept at cycle 0:
  - Word store: WRITE at 1, done_valid at 2.
  - Sub-word store: READ at 1, RDWAIT at 2, WRITE at 3, done_valid at 4.
  - Error: done_valid at 1, with no mem_re or mem_we ever asserted.
- req_ready is low from cycle 1 through the DONE cycle. The next accept is possible in the cycle after DONE.
- All outputs decode from registered state and registered latches, so there is no combinational path from req_* to mem_*.
- Reset asserted mid-operation: return to IDLE immediately and deassert mem_we and mem_re.
  - If reset lands before WRITE, memory is unmodified.
  - No done_valid is produced for the abandoned request.

## Structure
- Add to riscv_defs.sv: a STORE_STATE enum (IDLE, READ, RDWAIT, WRITE, DONE). MASK_SEL is reused as-is.
- Add to riscv_constants.sv: RG_SB_LANE_MASK (32'h0000_00FF) and RG_SH_LANE_MASK (32'h0000_FFFF), the base patterns for lane shifting. RG_SB_MASK and RG_SH_MASK stay as they are.
- One combinational sub-module, riscv_store_merge: inputs rdata, data, sel, offset[1:0]; output the merged word. It is reused by the bench's reference model.
- Target size: about 150–200 lines of FSM plus about 50 lines of merge.

## Test plan
- SW aligned: addr 0x100, data 0xDEADBEEF, MASK_X.
  - Expect mem_we at cycle 1 with mem_addr 0x100 and wdata 0xDEADBEEF.
  - done_valid at cycle 2, err = 0; mem_re never asserted.
- SB lane 2: RAM[0x200] = 0x11223344; addr 0x202, data 0xFFFFFFAB, MASK_B.
  - Expect mem_re at cycle 1, then mem_we at cycle 3 with wdata 0x11AB3344.
  - done_valid at cycle 4.
- SH upper lane: RAM[0x40] = 0xAAAABBBB; addr 0x42, data 0x12345678, MASK_H.
  - Expect wdata 0x5678BBBB.
- Misaligned and illegal: SH at 0x43, SW at 0x41, and MASK_B_SEXT at 0x40.
  - Each gives done_valid at cycle 1 with err = 1; mem_re and mem_we stay 0.
- Reset during RDWAIT of an SB to 0x300.
  - Expect state IDLE, mem_we never asserted, RAM[0x300] unchanged.
  - No done_valid; after release, req_ready = 1.
- Back-to-back: SB 0x10 immediately followed by SW 0x14, with req_valid held high.
  - Second accept occurs in the cycle after the first done_valid.
  - Both writes are correct; req_ready is low for the full duration of each operation.
